// File: rtl/sd_block_arbiter.sv
// sd_block_arbiter
// Shares one SPI-mode SD card controller between two block clients. Whole
// block transfers are granted round-robin. The block index is turned into a
// controller address, bytes are streamed to or from the granted client, read
// bytes are counted, and a stalled transfer is aborted by a timeout.
//
// Ports
//   i_clk, i_reset            clock, synchronous active-high reset
//   i_req[1:0]                per-client request level, held until o_done
//   i_we[1:0]                 per-client direction (1 = write), sampled at grant
//   i_block0/1                per-client block index, sampled at grant
//   i_wdata0/1                per-client write byte, presented after o_wstrb
//   o_grant[1:0]              one-hot owner of the controller
//   o_rdata, o_rvalid[1:0]    read byte and per-client valid pulse
//   o_wstrb[1:0]              per-client request for the next write byte
//   o_done[1:0], o_err        transfer finished pulse, error pulse
//   o_sd_reset                one-cycle controller reset on timeout
//   o_sd_rd_en, o_sd_wr_en    controller command enables
//   o_sd_addr, o_sd_wdata     controller address and write byte
//   i_sd_ready, i_sd_rdata    controller idle flag and read byte
//   i_sd_byte_avai            controller read byte strobe
//   i_sd_ready_wr             controller write byte request (level)
module sd_block_arbiter #(
    parameter int unsigned ADDR_SHIFT     = 9,
    parameter int unsigned BLOCK_BYTES    = 512,
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [1:0]  i_req,
    input  logic [1:0]  i_we,
    input  logic [22:0] i_block0,
    input  logic [22:0] i_block1,
    input  logic [7:0]  i_wdata0,
    input  logic [7:0]  i_wdata1,
    output logic [1:0]  o_grant,
    output logic [7:0]  o_rdata,
    output logic [1:0]  o_rvalid,
    output logic [1:0]  o_wstrb,
    output logic [1:0]  o_done,
    output logic        o_err,
    output logic        o_sd_reset,
    output logic        o_sd_rd_en,
    output logic        o_sd_wr_en,
    output logic [31:0] o_sd_addr,
    output logic [7:0]  o_sd_wdata,
    input  logic        i_sd_ready,
    input  logic [7:0]  i_sd_rdata,
    input  logic        i_sd_byte_avai,
    input  logic        i_sd_ready_wr
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 2);
    localparam int unsigned CW = 10;
    localparam logic [CW-1:0] CNT_MAX   = '1;
    localparam logic [CW-1:0] BLOCK_CNT = CW'(BLOCK_BYTES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_BUSY,
        S_XFER,
        S_FINISH,
        S_RECOVER
    } state_t;

    state_t         state;
    logic           ptr;        // preferred client for the next tie
    logic           gnt_idx;    // index of the granted client
    logic           we_q;
    logic [TW-1:0]  timer;
    logic [CW-1:0]  byte_cnt;
    logic           avai_q;
    logic           ready_wr_q;
    logic           wstrb_d;

    // Arbitration choice: preferred client if it asks, otherwise the other one.
    logic           sel_c;
    logic           we_sel_c;
    logic [22:0]    blk_sel_c;
    logic [31:0]    addr_c;
    logic           avai_rise_c;
    logic           wr_rise_c;
    logic           active_c;
    logic           timeout_c;

    assign sel_c       = i_req[ptr] ? ptr : !ptr;
    assign we_sel_c    = i_we[sel_c];
    assign blk_sel_c   = sel_c ? i_block1 : i_block0;
    assign addr_c      = 32'({9'b0, blk_sel_c} << ADDR_SHIFT);
    assign avai_rise_c = i_sd_byte_avai && !avai_q;
    assign wr_rise_c   = i_sd_ready_wr && !ready_wr_q;
    assign active_c    = (state == S_ISSUE) || (state == S_WAIT_BUSY) || (state == S_XFER);
    // Fires on the TIMEOUT_CYCLES-th active cycle after the grant.
    assign timeout_c   = timer <= TW'(1);

    // Arbiter FSM, byte streaming and timeout.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state      <= S_IDLE;
            ptr        <= 1'b0;
            gnt_idx    <= 1'b0;
            we_q       <= 1'b0;
            timer      <= '0;
            byte_cnt   <= '0;
            avai_q     <= 1'b0;
            ready_wr_q <= 1'b0;
            wstrb_d    <= 1'b0;
            o_grant    <= '0;
            o_rdata    <= '0;
            o_rvalid   <= '0;
            o_wstrb    <= '0;
            o_done     <= '0;
            o_err      <= 1'b0;
            o_sd_reset <= 1'b0;
            o_sd_rd_en <= 1'b0;
            o_sd_wr_en <= 1'b0;
            o_sd_addr  <= '0;
            o_sd_wdata <= '0;
        end else begin
            avai_q     <= i_sd_byte_avai;
            ready_wr_q <= i_sd_ready_wr;
            wstrb_d    <= |o_wstrb;
            o_rvalid   <= '0;
            o_wstrb    <= '0;
            o_done     <= '0;
            o_err      <= 1'b0;
            o_sd_reset <= 1'b0;

            // The client presents its byte the cycle after seeing o_wstrb.
            if (wstrb_d) begin
                o_sd_wdata <= gnt_idx ? i_wdata1 : i_wdata0;
            end

            if (active_c && timeout_c) begin
                o_sd_reset <= 1'b1;
                o_done     <= o_grant;
                o_err      <= 1'b1;
                o_grant    <= '0;
                o_sd_rd_en <= 1'b0;
                o_sd_wr_en <= 1'b0;
                state      <= S_RECOVER;
            end else begin
                if (active_c) begin
                    timer <= timer - TW'(1);
                end
                case (state)
                    S_IDLE: begin
                        if (i_sd_ready && (|i_req)) begin
                            gnt_idx    <= sel_c;
                            ptr        <= !sel_c;
                            we_q       <= we_sel_c;
                            o_sd_addr  <= addr_c;
                            o_grant    <= sel_c ? 2'b10 : 2'b01;
                            timer      <= TW'(TIMEOUT_CYCLES);
                            byte_cnt   <= '0;
                            o_sd_rd_en <= !we_sel_c;
                            o_sd_wr_en <= we_sel_c;
                            state      <= S_ISSUE;
                        end
                    end
                    S_ISSUE: begin
                        // Controller accepted the command once it leaves ready.
                        if (!i_sd_ready) begin
                            o_sd_rd_en <= 1'b0;
                            o_sd_wr_en <= 1'b0;
                            state      <= S_WAIT_BUSY;
                        end
                    end
                    S_WAIT_BUSY: begin
                        state <= S_XFER;
                    end
                    S_XFER: begin
                        if (!we_q && avai_rise_c) begin
                            o_rdata <= i_sd_rdata;
                            // Bytes beyond the block are CRC and stay hidden.
                            if (byte_cnt < BLOCK_CNT) begin
                                o_rvalid <= o_grant;
                            end
                            if (byte_cnt != CNT_MAX) begin
                                byte_cnt <= byte_cnt + CW'(1);
                            end
                        end
                        if (we_q && wr_rise_c) begin
                            o_wstrb <= o_grant;
                        end
                        if (i_sd_ready) begin
                            state <= S_FINISH;
                        end
                    end
                    S_FINISH: begin
                        o_done  <= o_grant;
                        o_err   <= !we_q && (byte_cnt < BLOCK_CNT);
                        o_grant <= '0;
                        state   <= S_IDLE;
                    end
                    S_RECOVER: begin
                        // Controller is re-initialising after o_sd_reset.
                        if (i_sd_ready) begin
                            state <= S_IDLE;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sd_block_arbiter.sv
// tb_sd_block_arbiter
// Directed bench for sd_block_arbiter: the bench plays both the SD
// controller and the two clients from one linear initial block.
module tb_sd_block_arbiter;

    localparam int unsigned TO = 3000;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic [1:0]  i_req;
    logic [1:0]  i_we;
    logic [22:0] i_block0;
    logic [22:0] i_block1;
    logic [7:0]  i_wdata0;
    logic [7:0]  i_wdata1;
    logic [1:0]  o_grant;
    logic [7:0]  o_rdata;
    logic [1:0]  o_rvalid;
    logic [1:0]  o_wstrb;
    logic [1:0]  o_done;
    logic        o_err;
    logic        o_sd_reset;
    logic        o_sd_rd_en;
    logic        o_sd_wr_en;
    logic [31:0] o_sd_addr;
    logic [7:0]  o_sd_wdata;
    logic        i_sd_ready;
    logic [7:0]  i_sd_rdata;
    logic        i_sd_byte_avai;
    logic        i_sd_ready_wr;

    always #5 i_clk = ~i_clk;

    sd_block_arbiter #(
        .ADDR_SHIFT     (9),
        .BLOCK_BYTES    (512),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_req          (i_req),
        .i_we           (i_we),
        .i_block0       (i_block0),
        .i_block1       (i_block1),
        .i_wdata0       (i_wdata0),
        .i_wdata1       (i_wdata1),
        .o_grant        (o_grant),
        .o_rdata        (o_rdata),
        .o_rvalid       (o_rvalid),
        .o_wstrb        (o_wstrb),
        .o_done         (o_done),
        .o_err          (o_err),
        .o_sd_reset     (o_sd_reset),
        .o_sd_rd_en     (o_sd_rd_en),
        .o_sd_wr_en     (o_sd_wr_en),
        .o_sd_addr      (o_sd_addr),
        .o_sd_wdata     (o_sd_wdata),
        .i_sd_ready     (i_sd_ready),
        .i_sd_rdata     (i_sd_rdata),
        .i_sd_byte_avai (i_sd_byte_avai),
        .i_sd_ready_wr  (i_sd_ready_wr)
    );

    int tests = 0;
    int fails = 0;

    // Pulse counters and invariant watch, sampled before each edge updates.
    int rv0 = 0, rv1 = 0, ws0 = 0, ws1 = 0, done0 = 0, done1 = 0, errs = 0, viol = 0;
    always @(posedge i_clk) begin
        if (o_rvalid[0]) rv0++;
        if (o_rvalid[1]) rv1++;
        if (o_wstrb[0])  ws0++;
        if (o_wstrb[1])  ws1++;
        if (o_done[0])   done0++;
        if (o_done[1])   done1++;
        if (o_err)       errs++;
        if (o_sd_rd_en && o_sd_wr_en) viol++;
        if (o_grant == 2'b11)         viol++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    function automatic logic [63:0] outs();
        return {4'b0, o_grant, o_rdata, o_rvalid, o_wstrb, o_done, o_err, o_sd_reset,
                o_sd_rd_en, o_sd_wr_en, o_sd_addr, o_sd_wdata};
    endfunction

    // Finish a granted transfer: controller goes busy, then returns ready.
    task automatic finish_xfer(input logic [1:0] oh, input logic exp_err,
                               input logic drop, input string tag);
        i_sd_ready = 1'b1;
        tick(2);
        chk({tag, "_done"}, o_done, oh);
        chk({tag, "_err"}, o_err, exp_err);
        chk({tag, "_grant_clr"}, o_grant, 2'b00);
        if (drop) i_req = i_req & ~oh;
        tick(1);
        chk({tag, "_done_once"}, o_done, 2'b00);
    endtask

    // Entry: negedge at which the read enable is visible.
    task automatic run_read(input int nbytes, input logic [1:0] oh, input logic exp_err,
                            input logic drop, input string tag);
        int bad;
        logic [7:0] val;
        logic [1:0] exp_rv;
        bad = 0;
        i_sd_ready = 1'b0;
        tick(1);
        chk({tag, "_en_drop"}, {o_sd_rd_en, o_sd_wr_en}, 2'b00);
        tick(1);
        for (int i = 0; i < nbytes; i++) begin
            val = 8'(i * 7 + 1);
            i_sd_rdata = val;
            i_sd_byte_avai = 1'b1;
            tick(1);
            exp_rv = (i < 512) ? oh : 2'b00;
            if (o_rvalid !== exp_rv || o_rdata !== val) bad++;
            i_sd_byte_avai = 1'b0;
            tick(1);
            if (o_rvalid !== 2'b00) bad++;
        end
        chk({tag, "_byte_errs"}, bad, 0);
        finish_xfer(oh, exp_err, drop, tag);
    endtask

    initial begin
        int bad;
        int cnt;
        int dsnap;
        i_reset = 1'b1;
        i_req = '0; i_we = '0; i_block0 = '0; i_block1 = '0;
        i_wdata0 = '0; i_wdata1 = '0;
        i_sd_ready = 1'b0; i_sd_rdata = '0; i_sd_byte_avai = 1'b0; i_sd_ready_wr = 1'b0;
        tick(3);
        chk("reset_outputs", outs(), 64'd0);
        i_reset = 1'b0;

        // Controller initialising: no grant until ready.
        i_req = 2'b01; i_we = 2'b00; i_block0 = 23'd3;
        tick(6);
        chk("no_grant_not_ready", o_grant, 2'b00);
        i_sd_ready = 1'b1;
        tick(1);
        chk("read0_grant", o_grant, 2'b01);
        chk("read0_rd_en", {o_sd_rd_en, o_sd_wr_en}, 2'b10);
        chk("read0_addr", o_sd_addr, 32'h600);
        run_read(514, 2'b01, 1'b0, 1'b1, "read0");
        chk("read0_rvalid_count", rv0, 512);
        chk("read0_no_rvalid1", rv1, 0);

        // Client1 writes block 5, dropping its request mid-transfer.
        i_req = 2'b10; i_we = 2'b10; i_block1 = 23'd5;
        tick(1);
        chk("write1_grant", o_grant, 2'b10);
        chk("write1_wr_en", {o_sd_rd_en, o_sd_wr_en}, 2'b01);
        chk("write1_addr", o_sd_addr, 32'hA00);
        i_req = 2'b00;
        i_sd_ready = 1'b0;
        tick(1);
        chk("write1_en_drop", {o_sd_rd_en, o_sd_wr_en}, 2'b00);
        tick(1);
        bad = 0;
        for (int i = 0; i < 512; i++) begin
            i_sd_ready_wr = 1'b1;
            tick(1);
            if (o_wstrb !== 2'b10) bad++;
            i_sd_ready_wr = 1'b0;
            i_wdata1 = 8'(i);
            i_wdata0 = ~8'(i);
            tick(2);
            if (o_sd_wdata !== 8'(i) || o_wstrb !== 2'b00) bad++;
        end
        chk("write1_byte_errs", bad, 0);
        finish_xfer(2'b10, 1'b0, 1'b1, "write1");
        chk("write1_wstrb_count", ws1, 512);
        chk("write1_no_wstrb0", ws0, 0);

        // Reset in the middle of a read: silent abort.
        i_req = 2'b01; i_we = 2'b00; i_block0 = 23'd9;
        tick(1);
        chk("rst_read_addr", o_sd_addr, 32'h1200);
        i_sd_ready = 1'b0;
        tick(2);
        for (int i = 0; i < 100; i++) begin
            i_sd_rdata = 8'(i); i_sd_byte_avai = 1'b1;
            tick(1);
            i_sd_byte_avai = 1'b0;
            tick(1);
        end
        dsnap = done0 + done1;
        i_reset = 1'b1;
        tick(1);
        chk("midreset_outputs", outs(), 64'd0);
        i_reset = 1'b0; i_req = 2'b00; i_sd_ready = 1'b1;
        tick(5);
        chk("midreset_no_done", done0 + done1, dsnap);

        // Both requesting: pointer restarts at client 0, then alternates.
        i_req = 2'b11; i_we = 2'b00; i_block0 = 23'd1; i_block1 = 23'd2;
        tick(1);
        chk("rr_grant_1", o_grant, 2'b01);
        chk("rr_addr_1", o_sd_addr, 32'h200);
        run_read(0, 2'b01, 1'b1, 1'b0, "rr1");
        chk("rr_grant_2", o_grant, 2'b10);
        chk("rr_addr_2", o_sd_addr, 32'h400);
        run_read(0, 2'b10, 1'b1, 1'b0, "rr2");
        chk("rr_grant_3", o_grant, 2'b01);
        run_read(0, 2'b01, 1'b1, 1'b0, "rr3");
        chk("rr_grant_4", o_grant, 2'b10);
        i_req = 2'b10;
        run_read(0, 2'b10, 1'b1, 1'b1, "rr4");
        chk("rr_idle_after", o_grant, 2'b00);

        // Stalled controller: timeout, controller reset, recover.
        i_req = 2'b10; i_we = 2'b00; i_block1 = 23'd4;
        tick(1);
        chk("to_grant", o_grant, 2'b10);
        i_sd_ready = 1'b0;
        cnt = 0;
        while (o_err !== 1'b1 && cnt < int'(TO) + 20) begin
            tick(1);
            cnt++;
        end
        chk("to_cycles", cnt, TO);
        chk("to_done", o_done, 2'b10);
        chk("to_sd_reset", o_sd_reset, 1'b1);
        chk("to_grant_clr", o_grant, 2'b00);
        i_req = 2'b01; i_block0 = 23'd6;
        tick(1);
        chk("to_sd_reset_pulse", {o_sd_reset, o_err, o_done}, 4'b0000);
        tick(8);
        chk("recover_no_grant", o_grant, 2'b00);
        i_sd_ready = 1'b1;
        tick(1);
        chk("recover_exit_no_grant", o_grant, 2'b00);
        tick(1);
        chk("recover_grant", o_grant, 2'b01);
        chk("recover_addr", o_sd_addr, 32'hC00);
        run_read(0, 2'b01, 1'b1, 1'b1, "rec");

        tick(3);
        chk("invariants", viol, 0);
        chk("done0_total", done0, 4);
        chk("done1_total", done1, 4);
        chk("err_total", errs, 6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
